vga_timing_gen: RTL

Produces the raster scan position (x, y) and video sync/blank signals that every sprite instance and the colour mux consume. The block has a free-running horizontal/vertical counter pair, advanced by a pixel clock-enable, with parameterised timing. It also produces frame, line and vblank strobes that the game logic uses to update object positions once per frame. The block sits at the top of the video path; its x/y outputs drive the sprite comparators directly.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_timing_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared raster types and default 640x480@60 timing for the video path.
// coord_t is the coordinate type that sprite and game logic also use.
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = 2048;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus sync/active flags registered from
// the next count, so they line up with count in the same cycle.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  output coord_t count,
  output logic   sync,
  output logic   active,
  output logic   wrap
);

  localparam int     TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam int     SYNC_LO = ACTIVE + FP;
  localparam int     SYNC_HI = ACTIVE + FP + SYNC;
  localparam coord_t LAST    = coord_t'(TOTAL - 1);

  if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_bad_total
    $error("vga_axis_counter: total of %0d does not fit an 11-bit coordinate", TOTAL);
  end

  coord_t count_nxt;

  // wrap is the current position being the last one; the next step returns to 0.
  assign wrap = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= LAST;
      sync   <= ~POL;
      active <= 1'b0;
    end else begin
      count  <= count_nxt;
      sync   <= (int'(count_nxt) >= SYNC_LO && int'(count_nxt) < SYNC_HI) ? POL : ~POL;
      active <= (int'(count_nxt) < ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster position, sync, display-enable and per-line/frame/vblank strobes.
// ce qualifies every clk: the raster moves one pixel only in clks with ce=1.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ce,
  output coord_t x,
  output coord_t y,
  output logic   hsync,
  output logic   vsync,
  output logic   de,
  output logic   line_start,
  output logic   frame_start,
  output logic   vblank_start
);

  localparam coord_t LAST_VISIBLE_LINE = coord_t'(V_ACTIVE - 1);

  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;
  logic v_step;

  // The vertical axis moves only on the ce that wraps x back to 0.
  assign v_step = h_wrap & ce;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL)
  ) u_h (
    .clk    (clk),
    .rst    (rst),
    .step   (ce),
    .count  (x),
    .sync   (hsync),
    .active (h_active),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL)
  ) u_v (
    .clk    (clk),
    .rst    (rst),
    .step   (v_step),
    .count  (y),
    .sync   (vsync),
    .active (v_active),
    .wrap   (v_wrap)
  );

  assign de = h_active & v_active;

  // Strobes are decoded from the pre-advance position, so they appear with the new x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      line_start   <= v_step;
      frame_start  <= v_step & v_wrap;
      vblank_start <= v_step & (y == LAST_VISIBLE_LINE);
    end
  end

endmodule
